// File: rtl/rv32_muldiv.sv
// rv32_muldiv: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Define RV32_MULDIV_SINGLE_CYCLE_MUL_EN to replace the shift-add multiplier with a one-cycle multiply.
module rv32_muldiv #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            stall_in,
    input  logic            flush_in,
    input  logic            valid_in,
    input  logic [2:0]      op_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    output logic            busy_out,
    output logic            valid_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result_out
);

    localparam int unsigned     DivIters = XLEN / DIV_BITS_PER_CYCLE;
    localparam int unsigned     CntW     = $clog2(XLEN);
    localparam logic [CntW-1:0] DivLast  = CntW'(DivIters - 1);
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    localparam logic [CntW-1:0] MulLast  = CntW'(XLEN - 1);
`endif
    localparam logic [XLEN-1:0] MinVal   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OneVal   = XLEN'(1);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpRem    = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
        StMul,
`endif
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_mag_q, b_mag_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] prod_q, prod_d;
`endif

    // Operand decode at accept
    logic            accept;
    logic            acc_a_signed, acc_b_signed;
    logic            acc_a_neg, acc_b_neg;
    logic [XLEN-1:0] acc_a_mag, acc_b_mag;

    // A new operation may enter when idle or when DONE retires this cycle.
    assign accept = valid_in && !flush_in &&
                    ((state_q == StIdle) || ((state_q == StDone) && !stall_in));

    always_comb begin
        acc_a_signed = (op_in == OpMulh) || (op_in == OpMulhsu) ||
                       (op_in == OpDiv) || (op_in == OpRem);
        acc_b_signed = (op_in == OpMulh) || (op_in == OpDiv) || (op_in == OpRem);
        acc_a_neg    = acc_a_signed && rs1_value_in[XLEN-1];
        acc_b_neg    = acc_b_signed && rs2_value_in[XLEN-1];
        acc_a_mag    = acc_a_neg ? -rs1_value_in : rs1_value_in;
        acc_b_mag    = acc_b_neg ? -rs2_value_in : rs2_value_in;
    end

`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    // Sign-extending both operands by one bit covers MUL, MULH, MULHSU and MULHU alike.
    logic signed [XLEN:0]     sc_a, sc_b;
    logic signed [2*XLEN-1:0] sc_prod;
    logic [XLEN-1:0]          sc_res;

    always_comb begin
        sc_a    = $signed({acc_a_signed & rs1_value_in[XLEN-1], rs1_value_in});
        sc_b    = $signed({acc_b_signed & rs2_value_in[XLEN-1], rs2_value_in});
        sc_prod = (2*XLEN)'(sc_a) * (2*XLEN)'(sc_b);
        sc_res  = (op_in == OpMul) ? sc_prod[XLEN-1:0] : sc_prod[2*XLEN-1:XLEN];
    end
`else
    // One shift-add step: multiplier sits in the low half and drains out to the right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_mag_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
    end
`endif

    // Restoring divide: quo_q starts as the dividend and fills with quotient bits.
    logic [XLEN:0]   div_rem;
    logic [XLEN:0]   div_trial;
    logic [XLEN-1:0] div_quo;

    always_comb begin
        div_rem   = {1'b0, rem_q};
        div_quo   = quo_q;
        div_trial = '0;
        for (int i = 0; i < int'(DIV_BITS_PER_CYCLE); i++) begin
            div_rem   = {div_rem[XLEN-1:0], div_quo[XLEN-1]};
            div_quo   = {div_quo[XLEN-2:0], 1'b0};
            div_trial = div_rem - {1'b0, b_mag_q};
            if (!div_trial[XLEN]) begin
                div_rem    = div_trial;
                div_quo[0] = 1'b1;
            end
        end
    end

    // Sign correction, word select and divide special cases
    logic [XLEN-1:0] quo_signed, rem_signed, dividend, fix_div, fix_res;
    logic            div_by_zero, div_ovf;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] prod_signed;
`endif

    always_comb begin
        quo_signed  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
        rem_signed  = a_neg_q ? -rem_q : rem_q;
        dividend    = a_neg_q ? -a_mag_q : a_mag_q;
        div_by_zero = (b_mag_q == '0);
        div_ovf     = a_neg_q && b_neg_q && (a_mag_q == MinVal) && (b_mag_q == OneVal);
        if (op_q[1]) begin
            fix_div = div_by_zero ? dividend : (div_ovf ? '0 : rem_signed);
        end else begin
            fix_div = div_by_zero ? '1 : (div_ovf ? dividend : quo_signed);
        end
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
        prod_signed = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
        if (op_q[2]) begin
            fix_res = fix_div;
        end else if (op_q == OpMul) begin
            fix_res = prod_signed[XLEN-1:0];
        end else begin
            fix_res = prod_signed[2*XLEN-1:XLEN];
        end
`else
        fix_res = fix_div;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
        prod_d   = prod_q;
`endif

        case (state_q)
            StIdle: ;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
            StMul: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == MulLast) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
`endif
            StDiv: begin
                rem_d = div_rem[XLEN-1:0];
                quo_d = div_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DivLast) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StFix: begin
                result_d = fix_res;
                rd_out_d = rd_q;
                state_d  = StDone;
            end
            StDone: begin
                if (!stall_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            op_d    = op_in;
            rd_d    = rd_in;
            a_neg_d = acc_a_neg;
            b_neg_d = acc_b_neg;
            a_mag_d = acc_a_mag;
            b_mag_d = acc_b_mag;
            cnt_d   = '0;
            if (op_in[2]) begin
                state_d = StDiv;
                rem_d   = '0;
                quo_d   = acc_a_mag;
            end else begin
`ifdef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
                state_d  = StDone;
                result_d = sc_res;
                rd_out_d = rd_in;
`else
                state_d = StMul;
                prod_d  = {{XLEN{1'b0}}, acc_a_mag};
`endif
            end
        end

        if (flush_in) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
`ifndef RV32_MULDIV_SINGLE_CYCLE_MUL_EN
            prod_q   <= prod_d;
`endif
        end
    end

    // DONE that retires this cycle no longer blocks issue.
    assign busy_out   = (state_q != StIdle) && !((state_q == StDone) && !stall_in);
    assign valid_out  = (state_q == StDone);
    assign rd_out     = rd_out_q;
    assign result_out = result_q;

endmodule
